// File: rtl/vigna_pkg.sv
// Shared definitions for the vigna instruction prefetcher.
package vigna_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/vigna_prefetch_if.sv
// Instruction bus between the prefetcher (master) and memory (slave).
interface vigna_prefetch_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;

    modport master (
        output i_valid, i_addr, i_wdata, i_wstrb,
        input  i_ready, i_rdata
    );

    modport slave (
        input  i_valid, i_addr, i_wdata, i_wstrb,
        output i_ready, i_rdata
    );
endinterface

// File: rtl/vigna_fifo.sv
// Circular prefetch buffer; head entry is read combinationally from storage.
module vigna_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Popping an empty buffer is a no-op; a push into a full buffer needs a same-cycle pop.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vigna_prefetch.sv
// Instruction prefetcher: keeps a small buffer of sequential words ahead of the core.
module vigna_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    vigna_prefetch_if.master       bus,
    output logic                   f_valid,
    input  logic                   f_ready,
    output logic [31:0]            f_inst,
    output logic [31:0]            f_pc,
    input  logic                   redir_valid,
    input  logic [31:0]            redir_pc,
    output logic [$clog2(DEPTH):0] level
);

    import vigna_pkg::*;

    localparam int unsigned  LW         = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] LAST_SLOT  = LW'(DEPTH - 1);

    fetch_state_t state, state_nxt;
    logic [31:0]  addr_q, addr_nxt;
    logic [31:0]  target_q, target_nxt;
    logic [31:0]  redir_target;
    logic         push;
    logic         pop;
    logic [63:0]  head;

    assign redir_target = align_pc(redir_pc);
    assign pop          = f_valid && f_ready;
    assign f_valid      = (level != '0);
    assign f_pc         = head[63:32];
    assign f_inst       = head[31:0];

    assign bus.i_valid  = (state != ST_IDLE);
    assign bus.i_addr   = addr_q;
    assign bus.i_wdata  = '0;
    assign bus.i_wstrb  = '0;

    vigna_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data ({addr_q, bus.i_rdata}),
        .pop       (pop),
        .flush     (redir_valid),
        .count     (level),
        .head      (head)
    );

    // State, current fetch address and deferred redirect target.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            addr_q   <= RESET_ADDR;
            target_q <= RESET_ADDR;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            target_q <= target_nxt;
        end
    end

    // Next-state logic; in IDLE addr_q already holds the next sequential fetch address.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        target_nxt = target_q;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (redir_valid) begin
                    state_nxt = ST_REQ;
                    addr_nxt  = redir_target;
                end else if (level < FULL_LEVEL) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redir_valid) begin
                    if (bus.i_ready) begin
                        state_nxt = ST_REQ;
                        addr_nxt  = redir_target;
                    end else begin
                        state_nxt  = ST_DRAIN;
                        target_nxt = redir_target;
                    end
                end else if (bus.i_ready) begin
                    push      = 1'b1;
                    addr_nxt  = addr_q + PC_STEP;
                    state_nxt = ((level < LAST_SLOT) || pop) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The stale response is consumed without writing; the newest redirect wins.
                if (redir_valid) target_nxt = redir_target;
                if (bus.i_ready) begin
                    state_nxt = ST_REQ;
                    addr_nxt  = redir_valid ? redir_target : target_q;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vigna_prefetch.sv
// Self-checking bench for vigna_prefetch: vector table, scoreboard and reset sequences.
module tb_vigna_prefetch;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    // Instance A: defaults, bench-controlled handshakes.
    vigna_prefetch_if bus_a();
    logic        ready_a = 1'b0;
    logic        f_ready_a = 1'b0;
    logic        redir_a = 1'b0;
    logic [31:0] redir_pc_a = '0;
    logic        f_valid_a;
    logic [31:0] f_inst_a, f_pc_a;
    logic [2:0]  level_a;

    assign bus_a.i_ready = ready_a;
    assign bus_a.i_rdata = word_of(bus_a.i_addr);

    vigna_prefetch #(.RESET_ADDR(32'h0000_0000), .DEPTH(4)) dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_a),
        .f_valid     (f_valid_a),
        .f_ready     (f_ready_a),
        .f_inst      (f_inst_a),
        .f_pc        (f_pc_a),
        .redir_valid (redir_a),
        .redir_pc    (redir_pc_a),
        .level       (level_a)
    );

    // Instance B: address wrap, always-ready memory, no consumer.
    vigna_prefetch_if bus_b();
    logic        f_valid_b;
    logic [31:0] f_inst_b, f_pc_b;
    logic [3:0]  level_b;

    assign bus_b.i_ready = 1'b1;
    assign bus_b.i_rdata = word_of(bus_b.i_addr);

    vigna_prefetch #(.RESET_ADDR(32'hFFFF_FFF8), .DEPTH(8)) dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_b),
        .f_valid     (f_valid_b),
        .f_ready     (1'b0),
        .f_inst      (f_inst_b),
        .f_pc        (f_pc_b),
        .redir_valid (1'b0),
        .redir_pc    (32'h0),
        .level       (level_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected fetch PCs, consumed whenever the core pops.
    logic [31:0] sb_q[$];
    logic [31:0] log_b[$];

    task automatic push_stream(input logic [31:0] start, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) sb_q.push_back(start + 32'(4 * k));
    endtask

    always @(negedge clk) begin
        if (f_valid_a && f_ready_a) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got pop of pc %h expected no pop", f_pc_a);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                check("sb_pc", f_pc_a, e);
                check("sb_inst", f_inst_a, word_of(e));
            end
        end
        if (bus_b.i_valid && bus_b.i_ready) log_b.push_back(bus_b.i_addr);
    end

    typedef struct {
        logic        f_ready;
        logic        i_ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [2:0]  exp_level;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int unsigned NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic fr, input logic ir, input logic rv, input logic [31:0] rp,
                                input logic ev, input logic [31:0] ea, input logic [2:0] el,
                                input logic [31:0] ep);
        vec_t v;
        v.f_ready = fr; v.i_ready = ir; v.redir = rv; v.redir_pc = rp;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_level = el; v.exp_pc = ep;
        return v;
    endfunction

    initial begin
        // Fill from reset, hold full, one pop refills, then redirect corner cases.
        vecs[0]  = mk(0, 1, 0, 32'h0,   1, 32'h0,   3'd0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,   1, 32'h4,   3'd1, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,   1, 32'h8,   3'd2, 32'h0);
        vecs[3]  = mk(0, 1, 0, 32'h0,   1, 32'hC,   3'd3, 32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0,   0, 32'h10,  3'd4, 32'h0);
        vecs[5]  = mk(0, 1, 0, 32'h0,   0, 32'h10,  3'd4, 32'h0);
        vecs[6]  = mk(1, 1, 0, 32'h0,   0, 32'h10,  3'd3, 32'h4);
        vecs[7]  = mk(0, 0, 0, 32'h0,   1, 32'h10,  3'd3, 32'h4);
        vecs[8]  = mk(0, 0, 1, 32'h100, 1, 32'h10,  3'd0, 32'h0);
        vecs[9]  = mk(0, 0, 0, 32'h0,   1, 32'h10,  3'd0, 32'h0);
        vecs[10] = mk(0, 0, 0, 32'h0,   1, 32'h10,  3'd0, 32'h0);
        vecs[11] = mk(0, 1, 0, 32'h0,   1, 32'h100, 3'd0, 32'h0);
        vecs[12] = mk(0, 1, 0, 32'h0,   1, 32'h104, 3'd1, 32'h100);
        vecs[13] = mk(0, 0, 0, 32'h0,   1, 32'h104, 3'd1, 32'h100);
        vecs[14] = mk(0, 1, 1, 32'h203, 1, 32'h200, 3'd0, 32'h0);
        vecs[15] = mk(0, 1, 0, 32'h0,   1, 32'h204, 3'd1, 32'h200);
        vecs[16] = mk(1, 0, 0, 32'h0,   1, 32'h204, 3'd0, 32'h0);
        vecs[17] = mk(0, 1, 0, 32'h0,   1, 32'h208, 3'd1, 32'h204);
        vecs[18] = mk(1, 0, 1, 32'h40,  1, 32'h208, 3'd0, 32'h0);
        vecs[19] = mk(0, 0, 1, 32'h80,  1, 32'h208, 3'd0, 32'h0);
        vecs[20] = mk(0, 1, 0, 32'h0,   1, 32'h80,  3'd0, 32'h0);
        vecs[21] = mk(0, 1, 0, 32'h0,   1, 32'h84,  3'd1, 32'h80);
        vecs[22] = mk(1, 0, 0, 32'h0,   1, 32'h84,  3'd0, 32'h0);
        vecs[23] = mk(1, 0, 0, 32'h0,   1, 32'h84,  3'd0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_i_valid", 32'(bus_a.i_valid), 32'h0);
        check("rst_i_addr",  bus_a.i_addr,       32'h0);
        check("rst_level",   32'(level_a),       32'h0);
        check("rst_f_valid", 32'(f_valid_a),     32'h0);
        check("rst_b_addr",  bus_b.i_addr,       32'hFFFF_FFF8);

        push_stream(32'h0, 4);
        resetn = 1'b1;

        for (int unsigned i = 0; i < NV; i++) begin
            f_ready_a  = vecs[i].f_ready;
            ready_a    = vecs[i].i_ready;
            redir_a    = vecs[i].redir;
            redir_pc_a = vecs[i].redir_pc;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_i_valid", i), 32'(bus_a.i_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_i_addr", i),  bus_a.i_addr,       vecs[i].exp_addr);
            check($sformatf("v%0d_level", i),   32'(level_a),       32'(vecs[i].exp_level));
            check($sformatf("v%0d_f_valid", i), 32'(f_valid_a),     32'(vecs[i].exp_level != 3'd0));
            if (vecs[i].exp_level != 3'd0)
                check($sformatf("v%0d_f_pc", i), f_pc_a, vecs[i].exp_pc);
            if (vecs[i].redir) begin
                sb_q.delete();
                push_stream(vecs[i].redir_pc & 32'hFFFF_FFFC, 8);
            end
        end
        f_ready_a = 1'b0;
        ready_a   = 1'b0;
        redir_a   = 1'b0;

        // Instance B wrapped across 2^32 and filled its 8 entries.
        check("b_log_size", 32'(log_b.size()), 32'd8);
        if (log_b.size() >= 3) begin
            check("b_addr0", log_b[0], 32'hFFFF_FFF8);
            check("b_addr1", log_b[1], 32'hFFFF_FFFC);
            check("b_addr2", log_b[2], 32'h0000_0000);
        end
        check("b_level",   32'(level_b),       32'd8);
        check("b_i_valid", 32'(bus_b.i_valid), 32'h0);
        check("b_i_addr",  bus_b.i_addr,       32'h18);
        check("b_f_pc",    f_pc_b,             32'hFFFF_FFF8);
        check("b_f_inst",  f_inst_b,           word_of(32'hFFFF_FFF8));

        // Asynchronous reset while a request is outstanding at 0x84.
        #2;
        resetn = 1'b0;
        #1;
        check("arst_i_valid", 32'(bus_a.i_valid), 32'h0);
        check("arst_level",   32'(level_a),       32'h0);
        check("arst_i_addr",  bus_a.i_addr,       32'h0);
        sb_q.delete();
        @(posedge clk);
        #1;
        check("arst_hold_valid", 32'(bus_a.i_valid), 32'h0);
        resetn  = 1'b1;
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        check("rel_i_valid", 32'(bus_a.i_valid), 32'h1);
        check("rel_i_addr",  bus_a.i_addr,       32'h0);
        @(posedge clk);
        #1;
        check("rel_level",  32'(level_a), 32'h1);
        check("rel_f_pc",   f_pc_a,       32'h0);
        check("rel_f_inst", f_inst_a,     word_of(32'h0));
        check("rel_i_addr2", bus_a.i_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vigna_prefetch.md
VIGNA_PREFETCH -- requirements
Module: vigna_prefetch

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; legal values are powers of 2 in the range 2..16.
REQ-003 Ports: clk  in  1  single clock; all state on rising edge.
REQ-004 Ports: resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 Ports: i_valid  out  1  bus request; i_ready  in  1  bus accept, with i_rdata valid in the same cycle.
REQ-006 Ports: i_addr  out  32  fetch address; i_rdata  in  32  instruction word.
REQ-007 Ports: i_wdata  out  32  tied 0; i_wstrb  out  4  tied 0.
REQ-008 Ports: f_valid  out  1  instruction available; f_ready  in  1  core consumes the head entry.
REQ-009 Ports: f_inst  out  32  head instruction; f_pc  out  32  head address.
REQ-010 Ports: redir_valid  in  1  flush and restart; redir_pc  in  32  new fetch address.
REQ-011 Ports: level  out  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-012 Bus protocol: once i_valid rises, i_valid and i_addr SHALL hold until the cycle in which i_ready=1.
REQ-013 At most one bus request SHALL be outstanding at a time.
REQ-014 A transfer occurs when i_valid&&i_ready; the word SHALL be written to the buffer with its address on that edge.
REQ-015 FSM states:
- IDLE: no request.
- REQ: request outstanding.
- DRAIN: a request issued before a redirect is still outstanding; its response is discarded.
REQ-016 IDLE->REQ when level+pending<DEPTH and no redirect is active; i_valid SHALL rise on the next edge.
REQ-017 REQ->REQ back-to-back on transfer when space remains after the write, with i_addr=previous+4; otherwise REQ->IDLE.
REQ-018 Address increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-019 f_valid SHALL equal (level!=0); f_inst and f_pc SHALL show the head entry combinationally from registered storage.
REQ-020 A pop occurs when f_valid&&f_ready; it SHALL have no effect when the buffer is empty.
REQ-021 Fill latency: a word accepted at edge N SHALL be visible with f_valid=1 after edge N (no bypass path).
REQ-022 Full buffer: a transfer and a pop in the same cycle keep level unchanged; a new request may issue only when level<DEPTH counting the pending slot.
REQ-023 On redir_valid=1, the buffer SHALL clear (level=0 on the next edge) and the next fetch address SHALL become {redir_pc[31:2],2'b00}.
REQ-024 Redirect while in IDLE: go to REQ, with i_addr=redirect target on the next edge.
REQ-025 Redirect while in REQ without i_ready: go to DRAIN; i_valid/i_addr stay unchanged until i_ready, and that response SHALL NOT be written; then DRAIN->REQ at the target.
REQ-026 Redirect in the same cycle as a transfer: the transferred word SHALL be discarded; go to REQ at the target.
REQ-027 Redirect in the same cycle as a pop: the redirect wins and the buffer ends empty.
REQ-028 A second redirect during DRAIN SHALL replace the pending target.

Reset
REQ-029 Async reset values:
- i_valid=0, i_addr=RESET_ADDR, f_valid=0, level=0.
- FSM=IDLE; read/write pointers 0.
REQ-030 Reset during an outstanding request SHALL abandon it; the first request after release SHALL use RESET_ADDR on the first clock edge after resetn rises.
REQ-031 Buffer data storage requires no reset.

Structure
REQ-032 The FSM state encoding and the PC step constant (4) SHALL live in shared package vigna_pkg.
REQ-033 Buffer SHALL be a sub-module vigna_fifo: parameters WIDTH=64 and DEPTH, with push, pop, flush, count and head outputs.
REQ-034 Target size: 150-300 lines of RTL in total.

Verification
REQ-035 Reset release, i_ready=1 always, f_ready=0 -> exactly DEPTH requests at 0,4,8,12 (DEPTH=4), then i_valid=0 and level=4.
REQ-036 Full buffer, f_ready=1 for 1 cycle -> one pop, f_pc advances 0->4, and one new request to 16 issues.
REQ-037 Redirect to 32'h100 while i_valid=1 and i_ready held 0 for 3 cycles -> i_addr stays on the old value until ready; that word is dropped; next request is 32'h100; the first f_pc after that is 32'h100.
REQ-038 Redirect to 32'h203 coincident with a transfer -> word dropped, level=0, next i_addr=32'h200.
REQ-039 RESET_ADDR=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 resetn pulsed low mid-request -> i_valid=0 immediately (asynchronous) and level=0; first request after release is at RESET_ADDR.
